// File: rtl/phase_align_ctrl.sv
// Phase alignment controller: settles, measures the phase detector, steps the
// phase shifter until lock. Optional lock tracking via PHASE_ALIGN_TRACK_EN.
module phase_align_ctrl #(
  parameter int SETTLE_CYCLES = 64,
  parameter int LOCK_WINDOW   = 256,
  parameter int MAX_STEPS     = 512,
  parameter int DONE_TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       shift_req,
  input  logic       ps_done,
  output logic       pd_enable,
  output logic       ps_step,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic [9:0] step_count,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_MEASURE   = 3'd2,
    S_STEP      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_LOCKED    = 3'd5,
    S_FAIL      = 3'd6
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_WINDOW - 1);
  localparam logic [15:0] DONE_LAST   = 16'(DONE_TIMEOUT - 1);
  localparam logic [9:0]  MAX_STEPS_W = 10'(MAX_STEPS);
  localparam logic [9:0]  COUNT_SAT   = 10'h3FF;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] timer;
  logic [15:0] timer_nxt;
  logic [9:0]  count_nxt;
  logic        track;
  logic        track_nxt;
  logic        begin_run;

  always_comb begin
    state_nxt = state;
    begin_run = 1'b0;
    case (state)
      S_IDLE, S_FAIL: begin
        if (start) begin
          state_nxt = S_SETTLE;
          begin_run = 1'b1;
        end
      end
      S_SETTLE: begin
        if (timer == SETTLE_LAST) state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        // a shift request beats an expiring lock window
        if (shift_req)               state_nxt = S_STEP;
        else if (timer == LOCK_LAST) state_nxt = S_LOCKED;
      end
      S_STEP: state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (ps_done) begin
          if (track)                         state_nxt = S_LOCKED;
          else if (step_count < MAX_STEPS_W) state_nxt = S_SETTLE;
          else                               state_nxt = S_FAIL;
        end else if (timer == DONE_LAST) begin
          state_nxt = S_FAIL;
        end
      end
      S_LOCKED: begin
        if (start) begin
          state_nxt = S_SETTLE;
          begin_run = 1'b1;
        end
`ifdef PHASE_ALIGN_TRACK_EN
        else if (shift_req) begin
          state_nxt = S_STEP;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
    if (stop) begin
      state_nxt = S_IDLE;
      begin_run = 1'b0;
    end
  end

  // One shared timer serves SETTLE, MEASURE and WAIT_DONE; it restarts on every state change.
  always_comb begin
    timer_nxt = 16'd0;
    if (state_nxt == state &&
        (state == S_SETTLE || state == S_MEASURE || state == S_WAIT_DONE))
      timer_nxt = timer + 16'd1;
  end

  always_comb begin
    count_nxt = step_count;
    if (begin_run)
      count_nxt = 10'd0;
    else if (state_nxt == S_STEP && state != S_STEP && step_count != COUNT_SAT)
      count_nxt = step_count + 10'd1;
  end

  always_comb begin
    track_nxt = 1'b0;
`ifdef PHASE_ALIGN_TRACK_EN
    if (state == S_LOCKED && state_nxt == S_STEP)
      track_nxt = 1'b1;
    else if (state_nxt == S_STEP || state_nxt == S_WAIT_DONE)
      track_nxt = track;
`endif
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= 16'd0;
      step_count <= 10'd0;
      track      <= 1'b0;
      pd_enable  <= 1'b0;
      ps_step    <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      step_count <= count_nxt;
      track      <= track_nxt;
      pd_enable  <= (state_nxt == S_MEASURE) || (state_nxt == S_LOCKED);
      ps_step    <= (state_nxt == S_STEP);
      busy       <= (state_nxt == S_SETTLE) || (state_nxt == S_MEASURE) ||
                    (state_nxt == S_STEP)   || (state_nxt == S_WAIT_DONE);
      locked     <= (state_nxt == S_LOCKED) || track_nxt;
      fail       <= (state_nxt == S_FAIL);
    end
  end

  assign state_dbg = state;

endmodule
